// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the bus-based CPU datapath: fetch in T0-T2,
// opcode-specific execute in T3-T7, with synchronous reset and a sticky HALT.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            stop,
  input  logic            con_ff,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Read,
  output logic            ramWE,
  output logic            Yin,
  output logic            ZLowIn,
  output logic            ZHighIn,
  output logic            ZLowout,
  output logic            ZHighout,
  output logic            HIin,
  output logic            LOin,
  output logic            HIout,
  output logic            LOout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            InPortout,
  output logic            OutPortIn,
  output logic [OPW-1:0]  alu_op,
  output logic            run,
  output logic [2:0]      step
);

  // T0..T7 encode their own step number so step/increment come straight from the state.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RESET = 4'd8, S_HALT = 4'd9
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_IN   = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  state_t         state_q, state_d;
  logic [OPW-1:0] opcode;
  logic [2:0]     last_step;
  logic           unused_inputs;

  assign opcode        = ir[31:32-OPW];
  assign unused_inputs = ^{con_ff, ir[31-OPW:0]};

  always_comb begin
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: last_step = 3'd5;
      OP_MUL, OP_DIV:                         last_step = 3'd6;
      OP_LD, OP_ST:                           last_step = 3'd7;
      default:                                last_step = 3'd3;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      S_T0, S_T1, S_T2: state_d = state_t'(state_q + 4'd1);
      default: begin
        if (state_q[2:0] == last_step)
          state_d = (stop || opcode == OP_HALT) ? S_HALT : S_T0;
        else
          state_d = state_t'(state_q + 4'd1);
      end
    endcase
  end

  // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, ramWE} = '0;
    {Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, InPortout, OutPortIn} = '0;
    alu_op = OP_ADD;
    run    = (state_q != S_RESET) && (state_q != S_HALT);
    step   = run ? state_q[2:0] : 3'd0;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      S_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_MUL, OP_DIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_LD, OP_ST:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        // Immediate/address forms add the constant; everything else runs its own ALU function.
        alu_op = opcode;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; end
          OP_ADDI, OP_LD, OP_ST: begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = OP_ADD; end
          OP_MUL, OP_DIV: begin Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MUL, OP_DIV: begin ZLowout = 1'b1; LOin = 1'b1; end
          OP_LD, OP_ST:   begin ZLowout = 1'b1; MARin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_MUL, OP_DIV: begin ZHighout = 1'b1; HIin = 1'b1; end
          OP_LD: begin Read = 1'b1; MDRin = 1'b1; end
          OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST: ramWE = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch and execute for each opcode
// class, mid-instruction reset, stop/halt handling and an unlisted opcode.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, stop, con_ff;
  logic [31:0] ir;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, ramWE;
  logic Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, InPortout, OutPortIn;
  logic [4:0]  alu_op;
  logic        run;
  logic [2:0]  step;
  logic [26:0] strobes;

  int checks   = 0;
  int failures = 0;

  localparam logic [26:0] PCOUT = 27'd1 << 26, PCIN = 27'd1 << 25, INCPC = 27'd1 << 24;
  localparam logic [26:0] MARIN = 27'd1 << 23, MDRIN = 27'd1 << 22, MDROUT = 27'd1 << 21;
  localparam logic [26:0] IRIN = 27'd1 << 20, READ = 27'd1 << 19, RAMWE = 27'd1 << 18;
  localparam logic [26:0] YIN = 27'd1 << 17, ZLOWIN = 27'd1 << 16, ZHIGHIN = 27'd1 << 15;
  localparam logic [26:0] ZLOWOUT = 27'd1 << 14, ZHIGHOUT = 27'd1 << 13, HIIN = 27'd1 << 12;
  localparam logic [26:0] LOIN = 27'd1 << 11, HIOUT = 27'd1 << 10, LOOUT = 27'd1 << 9;
  localparam logic [26:0] GRA = 27'd1 << 8, GRB = 27'd1 << 7, GRC = 27'd1 << 6;
  localparam logic [26:0] RIN = 27'd1 << 5, ROUT = 27'd1 << 4, BAOUT = 27'd1 << 3;
  localparam logic [26:0] COUT = 27'd1 << 2, INPORTOUT = 27'd1 << 1, OUTPORTIN = 27'd1 << 0;
  localparam logic [26:0] NONE = 27'd0;

  assign strobes = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, ramWE,
                    Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout,
                    Gra, Grb, Grc, Rin, Rout, BAout, Cout, InPortout, OutPortIn};

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop), .con_ff(con_ff),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Read(Read), .ramWE(ramWE),
    .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .InPortout(InPortout), .OutPortIn(OutPortIn),
    .alu_op(alu_op), .run(run), .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [26:0] exp_strb,
                             input logic [2:0] exp_step, input logic [4:0] exp_alu,
                             input logic exp_run);
    check({tag, ".strobes"}, 32'(strobes), 32'(exp_strb));
    check({tag, ".step"},    32'(step),    32'(exp_step));
    check({tag, ".alu_op"},  32'(alu_op),  32'(exp_alu));
    check({tag, ".run"},     32'(run),     32'(exp_run));
  endtask

  // Outputs are sampled on the falling edge, away from the state-register edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input string tag);
    check_state({tag, ".T0"}, PCOUT | MARIN | INCPC | ZLOWIN, 3'd0, 5'b00011, 1'b1); cyc();
    check_state({tag, ".T1"}, ZLOWOUT | PCIN | READ | MDRIN, 3'd1, 5'b00011, 1'b1);  cyc();
    check_state({tag, ".T2"}, MDROUT | IRIN, 3'd2, 5'b00011, 1'b1);                  cyc();
  endtask

  task automatic reset_pulse();
    clr = 1'b0; cyc();
    check_state("rst_pulse", NONE, 3'd0, 5'b00011, 1'b0);
    clr = 1'b1; cyc();
  endtask

  initial begin
    clr = 1'b0; stop = 1'b0; con_ff = 1'b0; ir = 32'hC2800000;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_state("reset", NONE, 3'd0, 5'b00011, 1'b0);
    clr = 1'b1; cyc();

    // mfhi R5
    fetch("mfhi");
    check_state("mfhi.T3", HIOUT | GRA | RIN, 3'd3, 5'b00011, 1'b1); cyc();

    // add R1,R2,R3 (con_ff toggled to show it has no effect)
    ir = 32'h18918000; con_ff = 1'b1;
    fetch("add");
    check_state("add.T3", GRB | ROUT | YIN, 3'd3, 5'b00011, 1'b1);     cyc();
    check_state("add.T4", GRC | ROUT | ZLOWIN, 3'd4, 5'b00011, 1'b1);  cyc();
    check_state("add.T5", ZLOWOUT | GRA | RIN, 3'd5, 5'b00011, 1'b1);  cyc();

    // sub: T4 alu_op follows the opcode
    ir = 32'h20000000; con_ff = 1'b0;
    fetch("sub");
    check_state("sub.T3", GRB | ROUT | YIN, 3'd3, 5'b00011, 1'b1);     cyc();
    check_state("sub.T4", GRC | ROUT | ZLOWIN, 3'd4, 5'b00100, 1'b1);  cyc();
    check_state("sub.T5", ZLOWOUT | GRA | RIN, 3'd5, 5'b00011, 1'b1);  cyc();

    // addi: T4 forces add even though opcode differs
    ir = 32'h60000000;
    fetch("addi");
    check_state("addi.T3", GRB | ROUT | YIN, 3'd3, 5'b00011, 1'b1);    cyc();
    check_state("addi.T4", COUT | ZLOWIN, 3'd4, 5'b00011, 1'b1);       cyc();
    check_state("addi.T5", ZLOWOUT | GRA | RIN, 3'd5, 5'b00011, 1'b1); cyc();

    // st
    ir = 32'h10800000;
    fetch("st");
    check_state("st.T3", GRB | BAOUT | YIN, 3'd3, 5'b00011, 1'b1);     cyc();
    check_state("st.T4", COUT | ZLOWIN, 3'd4, 5'b00011, 1'b1);         cyc();
    check_state("st.T5", ZLOWOUT | MARIN, 3'd5, 5'b00011, 1'b1);       cyc();
    check_state("st.T6", GRA | ROUT | MDRIN, 3'd6, 5'b00011, 1'b1);    cyc();
    check_state("st.T7", RAMWE, 3'd7, 5'b00011, 1'b1);                 cyc();

    // mul
    ir = 32'h78000000;
    fetch("mul");
    check_state("mul.T3", GRA | ROUT | YIN, 3'd3, 5'b00011, 1'b1);                cyc();
    check_state("mul.T4", GRB | ROUT | ZHIGHIN | ZLOWIN, 3'd4, 5'b01111, 1'b1);   cyc();
    check_state("mul.T5", ZLOWOUT | LOIN, 3'd5, 5'b00011, 1'b1);                  cyc();
    check_state("mul.T6", ZHIGHOUT | HIIN, 3'd6, 5'b00011, 1'b1);                 cyc();

    // ld full run
    ir = 32'h00000000;
    fetch("ld");
    check_state("ld.T3", GRB | BAOUT | YIN, 3'd3, 5'b00011, 1'b1);     cyc();
    check_state("ld.T4", COUT | ZLOWIN, 3'd4, 5'b00011, 1'b1);         cyc();
    check_state("ld.T5", ZLOWOUT | MARIN, 3'd5, 5'b00011, 1'b1);       cyc();
    check_state("ld.T6", READ | MDRIN, 3'd6, 5'b00011, 1'b1);          cyc();
    check_state("ld.T7", MDROUT | GRA | RIN, 3'd7, 5'b00011, 1'b1);    cyc();

    // ld aborted by reset in T4
    fetch("ldab");
    check_state("ldab.T3", GRB | BAOUT | YIN, 3'd3, 5'b00011, 1'b1);   cyc();
    check_state("ldab.T4", COUT | ZLOWIN, 3'd4, 5'b00011, 1'b1);
    clr = 1'b0; cyc();
    check_state("ldab.rst", NONE, 3'd0, 5'b00011, 1'b0);
    clr = 1'b1; cyc();

    // in / out
    ir = 32'hB0000000;
    fetch("in");
    check_state("in.T3", INPORTOUT | GRA | RIN, 3'd3, 5'b00011, 1'b1); cyc();
    ir = 32'hB8000000;
    fetch("out");
    check_state("out.T3", GRA | ROUT | OUTPORTIN, 3'd3, 5'b00011, 1'b1); cyc();

    // stop held through a non-final step must not halt; stop at T3 of mflo halts
    ir = 32'h18918000; stop = 1'b1;
    fetch("addstop");
    check_state("addstop.T3", GRB | ROUT | YIN, 3'd3, 5'b00011, 1'b1); cyc();
    check_state("addstop.T4", GRC | ROUT | ZLOWIN, 3'd4, 5'b00011, 1'b1);
    stop = 1'b0; cyc(); cyc();
    ir = 32'hC8000000;
    fetch("mflo");
    check_state("mflo.T3", LOOUT | GRA | RIN, 3'd3, 5'b00011, 1'b1);
    stop = 1'b1; cyc();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_state($sformatf("halt_hold%0d", i), NONE, 3'd0, 5'b00011, 1'b0);
      cyc();
    end
    reset_pulse();

    // halt opcode reaches HALT after T3 without stop
    ir = 32'hD8000000;
    fetch("halt");
    check_state("halt.T3", NONE, 3'd3, 5'b00011, 1'b1); cyc();
    check_state("halt.H0", NONE, 3'd0, 5'b00011, 1'b0); cyc();
    check_state("halt.H1", NONE, 3'd0, 5'b00011, 1'b0);
    reset_pulse();

    // clr and stop together at the last step: reset wins, so release goes to T0
    ir = 32'hC2800000;
    fetch("race");
    check_state("race.T3", HIOUT | GRA | RIN, 3'd3, 5'b00011, 1'b1);
    clr = 1'b0; stop = 1'b1; cyc();
    check_state("race.rst", NONE, 3'd0, 5'b00011, 1'b0);
    clr = 1'b1; stop = 1'b0; cyc();

    // unlisted opcode behaves as nop
    ir = 32'hF8000000;
    fetch("unl");
    check_state("unl.T3", NONE, 3'd3, 5'b00011, 1'b1); cyc();
    check_state("unl.next", PCOUT | MARIN | INCPC | ZLOWIN, 3'd0, 5'b00011, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
